// File: rtl/conv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_pkg : shared types and sizing helpers for the convolution frame path
// Rev 1.0
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_CONV_REQ  = 3'd2,
    ST_CONV_WAIT = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int LANES        = 4;
  localparam int PIX_PER_WORD = 3;

  function automatic int n_in(input int w, input int h);
    return (w * h + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

  function automatic int n_out(input int w, input int h);
    return ((w - 2) * (h - 2) + LANES - 1) / LANES;
  endfunction

  // Never let a derived address bus collapse to zero bits
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_out_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_out_packer : packs convolved pixels four per word into output-RAM writes
// Rev 1.0
// ---------------------------------------------------------------------------
module conv_out_packer
  import conv_pkg::*;
#(
  parameter int NB_PIX  = 8,
  parameter int NB_INST = 32,
  parameter int AW_OUT  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [NB_PIX-1:0]  i_result,
  input  logic               i_flush,
  output logic               o_out_we,
  output logic [AW_OUT-1:0]  o_out_waddr,
  output logic [NB_INST-1:0] o_out_wdata
);

  localparam int LW = (LANES - 1) * NB_PIX;

  logic [LW-1:0]      lanes_q, lanes_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [AW_OUT-1:0]  ptr_q, ptr_d;
  logic [AW_OUT-1:0]  waddr_q, waddr_d;
  logic [NB_INST-1:0] wdata_q, wdata_d;
  logic               we_q, we_d;

  // Lanes are zeroed after every emitted word, so a partial flush carries zeros up top
  always_comb begin
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (i_clear) begin
      lanes_d = '0;
      cnt_d   = '0;
      ptr_d   = '0;
    end else if (i_valid) begin
      if (cnt_q == 2'(LANES - 1)) begin
        we_d    = 1'b1;
        waddr_d = ptr_q;
        wdata_d = NB_INST'({i_result, lanes_q});
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = '0;
        lanes_d = '0;
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (cnt_q == 2'(k)) lanes_d[k*NB_PIX +: NB_PIX] = i_result;
        end
        cnt_d = cnt_q + 2'd1;
      end
    end else if (i_flush && (cnt_q != 2'd0)) begin
      we_d    = 1'b1;
      waddr_d = ptr_q;
      wdata_d = NB_INST'(lanes_q);
      ptr_d   = ptr_q + 1'b1;
      cnt_d   = '0;
      lanes_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lanes_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign o_out_we    = we_q;
  assign o_out_waddr = waddr_q;
  assign o_out_wdata = wdata_q;

endmodule
`default_nettype wire

// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_frame_ctrl : frame loader / window sequencer / result reader for the 3x3
// convolution engine. Optional CONV_TIMEOUT_EN adds an engine watchdog. Rev 1.0
// ---------------------------------------------------------------------------
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter  int NB_PIX  = 8,
  parameter  int NB_DATA = 24,
  parameter  int NB_INST = 32,
  parameter  int IMG_W   = 32,
  parameter  int IMG_H   = 32,
  parameter  int TIMEOUT = 64,
  localparam int N_IN    = n_in(IMG_W, IMG_H),
  localparam int N_OUT   = n_out(IMG_W, IMG_H),
  localparam int AW_IN   = addr_w(N_IN),
  localparam int AW_OUT  = addr_w(N_OUT),
  localparam int AW_R    = addr_w(IMG_H - 2),
  localparam int AW_C    = addr_w(IMG_W - 2)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_pixels,
  input  logic               i_start_conv,
  input  logic [1:0]         i_kernel_sel,
  input  logic               i_get_frame,
  output logic               o_in_we,
  output logic [AW_IN-1:0]   o_in_waddr,
  output logic [NB_DATA-1:0] o_in_wdata,
  output logic               o_conv_req,
  output logic [AW_R-1:0]    o_conv_row,
  output logic [AW_C-1:0]    o_conv_col,
  output logic [1:0]         o_kernel_sel,
  input  logic               i_conv_done,
  input  logic [NB_PIX-1:0]  i_conv_result,
  output logic               o_out_we,
  output logic [AW_OUT-1:0]  o_out_waddr,
  output logic [NB_INST-1:0] o_out_wdata,
  output logic [AW_OUT-1:0]  o_out_raddr,
  output logic               o_frame_ready,
  output logic               o_busy
`ifdef CONV_TIMEOUT_EN
  ,
  output logic               o_timeout
`endif
);

  state_e            state_q, state_d;
  logic [AW_IN-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW_R-1:0]   row_q, row_d;
  logic [AW_C-1:0]   col_q, col_d;
  logic [1:0]        kernel_q, kernel_d;
  logic [AW_OUT-1:0] rd_ptr_q, rd_ptr_d;
  logic              idle_like, result_valid, pack_clear, pack_flush, to_fire, last_win;
  logic [NB_PIX-1:0] result;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign last_win  = (row_q == AW_R'(IMG_H - 3)) && (col_q == AW_C'(IMG_W - 3));

`ifdef CONV_TIMEOUT_EN
  localparam int TW = addr_w(TIMEOUT);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q, to_flag_d;

  assign to_fire = (state_q == ST_CONV_WAIT) && !i_conv_done && (to_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d  = (state_q == ST_CONV_WAIT) ? to_cnt_q + 1'b1 : '0;
    to_flag_d = to_flag_q;
    if (to_fire) to_flag_d = 1'b1;
    else if (i_load && (state_q == ST_IDLE || state_q == ST_DONE)) to_flag_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign o_timeout = to_flag_q;
`else
  assign to_fire = 1'b0;
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // A timed-out window is recorded as a zero pixel and the scan carries on
  assign result_valid = (state_q == ST_CONV_WAIT) && (i_conv_done || to_fire);
  assign result       = i_conv_done ? i_conv_result : '0;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    row_d      = row_q;
    col_d      = col_q;
    kernel_d   = kernel_q;
    rd_ptr_d   = '0;
    pack_clear = 1'b0;
    pack_flush = 1'b0;
    o_in_we    = 1'b0;
    o_in_waddr = '0;
    if (idle_like) begin
      o_in_we    = i_load && !reset;
      o_in_waddr = (state_q == ST_LOAD) ? wr_ptr_q : '0;
      if (i_load) begin
        state_d = ST_LOAD;
        if (state_q != ST_LOAD) wr_ptr_d = AW_IN'(1);
        else if (wr_ptr_q != AW_IN'(N_IN - 1)) wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (i_start_conv) begin
        state_d    = ST_CONV_REQ;
        kernel_d   = i_kernel_sel;
        row_d      = '0;
        col_d      = '0;
        pack_clear = 1'b1;
      end
    end
    if (state_q == ST_DONE) begin
      rd_ptr_d = rd_ptr_q;
      if (i_get_frame) rd_ptr_d = (rd_ptr_q == AW_OUT'(N_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (state_q == ST_CONV_REQ) state_d = ST_CONV_WAIT;
    if (result_valid) begin
      if (col_q == AW_C'(IMG_W - 3)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      state_d = last_win ? ST_FLUSH : ST_CONV_REQ;
    end
    if (state_q == ST_FLUSH) begin
      pack_flush = 1'b1;
      state_d    = ST_DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      kernel_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      kernel_q <= kernel_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  conv_out_packer #(
    .NB_PIX  (NB_PIX),
    .NB_INST (NB_INST),
    .AW_OUT  (AW_OUT)
  ) u_packer (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (pack_clear),
    .i_valid     (result_valid),
    .i_result    (result),
    .i_flush     (pack_flush),
    .o_out_we    (o_out_we),
    .o_out_waddr (o_out_waddr),
    .o_out_wdata (o_out_wdata)
  );

  assign o_in_wdata    = o_in_we ? i_pixels : '0;
  assign o_conv_req    = (state_q == ST_CONV_REQ) || (state_q == ST_CONV_WAIT);
  assign o_conv_row    = row_q;
  assign o_conv_col    = col_q;
  assign o_kernel_sel  = kernel_q;
  assign o_out_raddr   = rd_ptr_q;
  assign o_frame_ready = (state_q == ST_DONE);
  assign o_busy        = (state_q == ST_CONV_REQ) || (state_q == ST_CONV_WAIT) || (state_q == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
// tb_conv_frame_ctrl : directed bench, 6x6 frame (dut0) and 5x5 frame (dut1) side by side,
// each served by its own engine model returning row*16+col three cycles after a request.
module tb_conv_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_load, i_start_conv, i_get_frame;
  logic [23:0] i_pixels;
  logic [1:0]  i_kernel_sel;
  logic [1:0]  conv_done;
  logic [7:0]  conv_result [2];
  logic        silent;

  logic        in_we0, req0, out_we0, ready0, busy0, timeout0;
  logic [3:0]  in_waddr0;
  logic [23:0] in_wdata0;
  logic [1:0]  row0, col0, ksel0, out_waddr0, raddr0;
  logic [31:0] out_wdata0;
  logic        in_we1, req1, out_we1, ready1, busy1, timeout1;
  logic [3:0]  in_waddr1;
  logic [23:0] in_wdata1;
  logic [1:0]  row1, col1, ksel1, out_waddr1, raddr1;
  logic [31:0] out_wdata1;

  int vectors = 0;
  int miscompares = 0;
  int in_we_cnt, nw0, nw1;
  logic [31:0] mem0 [4];
  logic [31:0] mem1 [4];
  int eng_cnt [2];
  int last_key [2];
  int nreq [2];
  int rq_key [2][32];

`ifdef CONV_TIMEOUT_EN
  localparam logic [31:0] EXP_W1 = 32'h1300_1110;
`else
  localparam logic [31:0] EXP_W1 = 32'h1312_1110;
`endif

  always #5 clock = ~clock;

  conv_frame_ctrl #(.IMG_W(6), .IMG_H(6), .TIMEOUT(8)) dut0 (
    .clock(clock), .reset(reset), .i_load(i_load), .i_pixels(i_pixels),
    .i_start_conv(i_start_conv), .i_kernel_sel(i_kernel_sel), .i_get_frame(i_get_frame),
    .o_in_we(in_we0), .o_in_waddr(in_waddr0), .o_in_wdata(in_wdata0),
    .o_conv_req(req0), .o_conv_row(row0), .o_conv_col(col0), .o_kernel_sel(ksel0),
    .i_conv_done(conv_done[0]), .i_conv_result(conv_result[0]),
    .o_out_we(out_we0), .o_out_waddr(out_waddr0), .o_out_wdata(out_wdata0),
    .o_out_raddr(raddr0), .o_frame_ready(ready0), .o_busy(busy0)
`ifdef CONV_TIMEOUT_EN
    , .o_timeout(timeout0)
`endif
  );

  conv_frame_ctrl #(.IMG_W(5), .IMG_H(5)) dut1 (
    .clock(clock), .reset(reset), .i_load(i_load), .i_pixels(i_pixels),
    .i_start_conv(i_start_conv), .i_kernel_sel(i_kernel_sel), .i_get_frame(i_get_frame),
    .o_in_we(in_we1), .o_in_waddr(in_waddr1), .o_in_wdata(in_wdata1),
    .o_conv_req(req1), .o_conv_row(row1), .o_conv_col(col1), .o_kernel_sel(ksel1),
    .i_conv_done(conv_done[1]), .i_conv_result(conv_result[1]),
    .o_out_we(out_we1), .o_out_waddr(out_waddr1), .o_out_wdata(out_wdata1),
    .o_out_raddr(raddr1), .o_frame_ready(ready1), .o_busy(busy1)
`ifdef CONV_TIMEOUT_EN
    , .o_timeout(timeout1)
`endif
  );

`ifndef CONV_TIMEOUT_EN
  assign timeout0 = 1'b0;
  assign timeout1 = 1'b0;
`endif

  // Engine models; a request is logged once per distinct window coordinate
  always begin : engine
    int   key;
    logic r;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      conv_done[k] = 1'b0;
      r   = (k == 0) ? req0 : req1;
      key = (k == 0) ? (int'(row0) * 16 + int'(col0)) : (int'(row1) * 16 + int'(col1));
      if (reset) begin
        eng_cnt[k]  = 0;
        last_key[k] = -1;
      end else if (eng_cnt[k] > 0) begin
        eng_cnt[k] = eng_cnt[k] - 1;
        if (eng_cnt[k] == 0) conv_done[k] = 1'b1;
      end else if (r) begin
        if (key != last_key[k]) begin
          if (nreq[k] < 32) rq_key[k][nreq[k]] = key;
          nreq[k]     = nreq[k] + 1;
          last_key[k] = key;
        end
        if (!(silent && k == 0 && key == 'h12)) begin
          conv_result[k] = 8'(key);
          eng_cnt[k]     = 3;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (in_we0) in_we_cnt = in_we_cnt + 1;
    if (out_we0) begin
      mem0[out_waddr0] = out_wdata0;
      nw0 = nw0 + 1;
    end
    if (out_we1) begin
      mem1[out_waddr1] = out_wdata1;
      nw1 = nw1 + 1;
    end
  end

  task automatic clear_logs();
    nw0 = 0; nw1 = 0; nreq[0] = 0; nreq[1] = 0;
    for (int i = 0; i < 4; i++) begin mem0[i] = '0; mem1[i] = '0; end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready0 && ready1) && n < 3000) begin @(negedge clock); n++; end
    vectors++;
    if (!(ready0 && ready1)) begin
      miscompares++;
      $display("FAIL frame_ready_timeout: got %b%b required 11", ready0, ready1);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", busy0); end
    vectors++; if (req0 !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b required 0", req0); end
    vectors++; if (ready0 !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", ready0); end
    vectors++; if ({in_we0, in_waddr0, in_wdata0} !== '0) begin miscompares++; $display("FAIL rst_inport: got %h required 0", {in_we0, in_waddr0, in_wdata0}); end
    vectors++; if ({out_we0, out_waddr0, out_wdata0, raddr0, ksel0} !== '0) begin miscompares++; $display("FAIL rst_outport: got %h required 0", {out_we0, out_waddr0, out_wdata0, raddr0, ksel0}); end
  endtask

  task automatic test_load();
    logic [23:0] px;
    in_we_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      px = {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)};
      @(posedge clock); #1 i_load = 1'b1; i_pixels = px;
      @(negedge clock);
      vectors++; if (in_waddr0 !== 4'(i)) begin miscompares++; $display("FAIL load_waddr[%0d]: got %0d required %0d", i, in_waddr0, i); end
      vectors++; if (in_wdata0 !== px) begin miscompares++; $display("FAIL load_wdata[%0d]: got %h required %h", i, in_wdata0, px); end
    end
    @(posedge clock); #1 i_load = 1'b0;
    @(negedge clock);
    vectors++; if (in_we_cnt !== 12) begin miscompares++; $display("FAIL load_we_pulses: got %0d required 12", in_we_cnt); end
  endtask

  task automatic test_conv();
    clear_logs();
    @(posedge clock); #1 i_start_conv = 1'b1; i_kernel_sel = 2'd2;
    @(posedge clock); #1 i_start_conv = 1'b0;
    @(negedge clock);
    vectors++; if ({req0, busy0} !== 2'b11) begin miscompares++; $display("FAIL conv_start: got %b required 11", {req0, busy0}); end
    vectors++; if (ksel0 !== 2'd2) begin miscompares++; $display("FAIL conv_kernel: got %0d required 2", ksel0); end
    wait_ready();
    vectors++; if (nreq[0] !== 16) begin miscompares++; $display("FAIL conv_nreq: got %0d required 16", nreq[0]); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rq_key[0][i] !== (i / 4) * 16 + (i % 4)) begin
        miscompares++; $display("FAIL conv_order[%0d]: got %h required %h", i, rq_key[0][i], (i / 4) * 16 + (i % 4));
      end
    end
    vectors++; if (nw0 !== 4) begin miscompares++; $display("FAIL conv_nwrites6: got %0d required 4", nw0); end
    vectors++; if (mem0[0] !== 32'h0302_0100) begin miscompares++; $display("FAIL conv_word0: got %h required 03020100", mem0[0]); end
    vectors++; if (mem0[1] !== EXP_W1) begin miscompares++; $display("FAIL conv_word1: got %h required %h", mem0[1], EXP_W1); end
    vectors++; if (mem0[3] !== 32'h3332_3130) begin miscompares++; $display("FAIL conv_word3: got %h required 33323130", mem0[3]); end
    vectors++; if (nw1 !== 3) begin miscompares++; $display("FAIL conv_nwrites5: got %0d required 3", nw1); end
    vectors++; if (mem1[0] !== 32'h1002_0100) begin miscompares++; $display("FAIL conv5_word0: got %h required 10020100", mem1[0]); end
    vectors++; if (mem1[2] !== 32'h0000_0022) begin miscompares++; $display("FAIL conv5_word2: got %h required 00000022", mem1[2]); end
    vectors++; if ({busy0, busy1} !== 2'b00) begin miscompares++; $display("FAIL conv_busy_done: got %b required 00", {busy0, busy1}); end
`ifdef CONV_TIMEOUT_EN
    vectors++; if ({timeout0, timeout1} !== 2'b10) begin miscompares++; $display("FAIL conv_timeout_flag: got %b required 10", {timeout0, timeout1}); end
`endif
  endtask

  task automatic test_get_frame();
    logic [1:0] exp;
    vectors++; if (raddr0 !== 2'd0) begin miscompares++; $display("FAIL get_raddr_init: got %0d required 0", raddr0); end
    for (int j = 0; j < 5; j++) begin
      exp = 2'((j + 1) % 4);
      @(posedge clock); #1 i_get_frame = 1'b1;
      @(posedge clock); #1 i_get_frame = 1'b0;
      @(negedge clock);
      vectors++; if (raddr0 !== exp) begin miscompares++; $display("FAIL get_raddr[%0d]: got %0d required %0d", j, raddr0, exp); end
    end
  endtask

  task automatic test_end_frame();
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1 i_load = 1'b1; i_pixels = 24'(i * 'h111);
      i_start_conv = (i == 11); i_kernel_sel = 2'd1;
      @(negedge clock);
      vectors++; if ({in_we0, in_waddr0} !== {1'b1, 4'(i)}) begin miscompares++; $display("FAIL ef_waddr[%0d]: got %h required %h", i, {in_we0, in_waddr0}, {1'b1, 4'(i)}); end
      if (i == 1) begin
        vectors++; if (ready0 !== 1'b0) begin miscompares++; $display("FAIL ef_ready_clear: got %b required 0", ready0); end
`ifdef CONV_TIMEOUT_EN
        vectors++; if (timeout0 !== 1'b0) begin miscompares++; $display("FAIL ef_timeout_clear: got %b required 0", timeout0); end
`endif
      end
      if (i == 11) begin
        vectors++; if (req0 !== 1'b0) begin miscompares++; $display("FAIL ef_req_early: got %b required 0", req0); end
      end
    end
    @(posedge clock); #1 i_load = 1'b0; i_start_conv = 1'b0;
    @(negedge clock);
    vectors++; if ({req0, ksel0} !== 3'b101) begin miscompares++; $display("FAIL ef_conv_start: got %b required 101", {req0, ksel0}); end
    wait_ready();
    vectors++; if (nw0 !== 4) begin miscompares++; $display("FAIL ef_nwrites: got %0d required 4", nw0); end
    vectors++; if (mem0[0] !== 32'h0302_0100) begin miscompares++; $display("FAIL ef_word0: got %h required 03020100", mem0[0]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1 i_start_conv = 1'b1; i_kernel_sel = 2'd3;
    @(posedge clock); #1 i_start_conv = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL rm_busy_before: got %b required 1", busy0); end
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++; if ({busy0, req0, ready0, ksel0, row0, col0} !== '0) begin miscompares++; $display("FAIL rm_ctrl: got %h required 0", {busy0, req0, ready0, ksel0, row0, col0}); end
    vectors++; if ({out_we0, out_waddr0, out_wdata0, raddr0} !== '0) begin miscompares++; $display("FAIL rm_outport: got %h required 0", {out_we0, out_waddr0, out_wdata0, raddr0}); end
    vectors++; if ({in_we0, in_waddr0, in_wdata0, timeout0} !== '0) begin miscompares++; $display("FAIL rm_inport: got %h required 0", {in_we0, in_waddr0, in_wdata0, timeout0}); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++; if ({busy0, req0} !== 2'b00) begin miscompares++; $display("FAIL rm_idle_after: got %b required 00", {busy0, req0}); end
  endtask

  initial begin
    reset = 1'b1; i_load = 1'b0; i_pixels = '0; i_start_conv = 1'b0;
    i_kernel_sel = '0; i_get_frame = 1'b0; conv_done = '0;
    conv_result[0] = '0; conv_result[1] = '0;
    in_we_cnt = 0;
`ifdef CONV_TIMEOUT_EN
    silent = 1'b1;
`else
    silent = 1'b0;
`endif
    clear_logs();
    test_reset();
    test_load();
    test_conv();
    test_get_frame();
    test_end_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
